// File: rtl/icache_tl_arbiter_if.sv
// Bus bundle for icache_tl_arbiter: two requester ports (A request, D response)
// plus the TileLink-UH A and D channels toward the interconnect.
//   master : arbiter view (accepts requester A, drives TL A, routes TL D back)
//   slave  : environment view (requesters and interconnect)
interface icache_tl_arbiter_if;
    logic        req0_a_valid;
    logic        req0_a_ready;
    logic [2:0]  req0_a_opcode;
    logic [3:0]  req0_a_size;
    logic [31:0] req0_a_address;
    logic        req0_d_valid;
    logic        req0_d_ready;
    logic [31:0] req0_d_data;
    logic        req0_d_denied;
    logic        req0_d_corrupt;
    logic        req0_d_last;

    logic        req1_a_valid;
    logic        req1_a_ready;
    logic [2:0]  req1_a_opcode;
    logic [3:0]  req1_a_size;
    logic [31:0] req1_a_address;
    logic        req1_d_valid;
    logic        req1_d_ready;
    logic [31:0] req1_d_data;
    logic        req1_d_denied;
    logic        req1_d_corrupt;
    logic        req1_d_last;

    logic [2:0]  tl_a_opcode;
    logic [2:0]  tl_a_param;
    logic [3:0]  tl_a_size;
    logic [31:0] tl_a_address;
    logic [3:0]  tl_a_mask;
    logic [31:0] tl_a_data;
    logic        tl_a_corrupt;
    logic        tl_a_valid;
    logic        tl_a_ready;

    logic [2:0]  tl_d_opcode;
    logic [1:0]  tl_d_param;
    logic [3:0]  tl_d_size;
    logic        tl_d_denied;
    logic [31:0] tl_d_data;
    logic        tl_d_corrupt;
    logic        tl_d_valid;
    logic        tl_d_ready;

    modport master (
        input  req0_a_valid, req0_a_opcode, req0_a_size, req0_a_address, req0_d_ready,
        output req0_a_ready, req0_d_valid, req0_d_data, req0_d_denied, req0_d_corrupt, req0_d_last,
        input  req1_a_valid, req1_a_opcode, req1_a_size, req1_a_address, req1_d_ready,
        output req1_a_ready, req1_d_valid, req1_d_data, req1_d_denied, req1_d_corrupt, req1_d_last,
        output tl_a_opcode, tl_a_param, tl_a_size, tl_a_address, tl_a_mask, tl_a_data,
        output tl_a_corrupt, tl_a_valid,
        input  tl_a_ready,
        input  tl_d_opcode, tl_d_param, tl_d_size, tl_d_denied, tl_d_data, tl_d_corrupt, tl_d_valid,
        output tl_d_ready
    );

    modport slave (
        output req0_a_valid, req0_a_opcode, req0_a_size, req0_a_address, req0_d_ready,
        input  req0_a_ready, req0_d_valid, req0_d_data, req0_d_denied, req0_d_corrupt, req0_d_last,
        output req1_a_valid, req1_a_opcode, req1_a_size, req1_a_address, req1_d_ready,
        input  req1_a_ready, req1_d_valid, req1_d_data, req1_d_denied, req1_d_corrupt, req1_d_last,
        input  tl_a_opcode, tl_a_param, tl_a_size, tl_a_address, tl_a_mask, tl_a_data,
        input  tl_a_corrupt, tl_a_valid,
        output tl_a_ready,
        output tl_d_opcode, tl_d_param, tl_d_size, tl_d_denied, tl_d_data, tl_d_corrupt, tl_d_valid,
        input  tl_d_ready
    );
endinterface

// File: rtl/icache_tl_arbiter.sv
// Two-requester arbiter for the instruction-side TileLink-UH master port.
// Requester 0 = demand refill, requester 1 = prefetch / maintenance. One bus
// transaction in flight; multi-beat D responses are routed back to the owner,
// and a flush drains the remaining beats without delivering them.
//
// Ports:
//   core_clock_i   clock, rising edge
//   core_reset_ni  asynchronous active-low reset
//   flush_i        discard the in-flight response
//   busy_o         high whenever not IDLE
//   bus            icache_tl_arbiter_if.master (requester A/D + TL A/D channels)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transaction; arbitrate and grant one requester
// S_A_SEND | tl_a_valid held with latched fields until tl_a_ready
// S_D_WAIT | route D beats to owner (or drop if discarding) until last beat
module icache_tl_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_SIZE     = 6
) (
    input  logic                core_clock_i,
    input  logic                core_reset_ni,
    input  logic                flush_i,
    output logic                busy_o,
    icache_tl_arbiter_if.master bus
);

    localparam int BW = MAX_SIZE - 2;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_A_SEND = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic          discard_q, discard_d;
    logic [SW-1:0] starve_q,  starve_d;
    logic [BW-1:0] beat_q,    beat_d;
    logic          owner_q,   owner_d;
    logic [2:0]    opcode_q,  opcode_d;
    logic [3:0]    size_q,    size_d;
    logic [31:0]   addr_q,    addr_d;

    logic          in_idle, in_asend, in_dwait;
    logic          grant0, grant1;
    logic [3:0]    sel_size;
    logic [BW-1:0] beat_init;
    logic          owner_vld, owner_rdy, d_acc;
    logic          unused_d;

    assign in_idle  = (state_q == S_IDLE);
    assign in_asend = (state_q == S_A_SEND);
    assign in_dwait = (state_q == S_D_WAIT);

    // req1 wins when alone, or when req0 has already been favoured STARVE_LIMIT times in a row.
    assign grant1 = bus.req1_a_valid & (~bus.req0_a_valid | (starve_q == SW'(STARVE_LIMIT)));
    assign grant0 = bus.req0_a_valid & ~grant1;

    assign bus.req0_a_ready = in_idle & grant0;
    assign bus.req1_a_ready = in_idle & grant1;

    assign sel_size  = grant1 ? bus.req1_a_size : bus.req0_a_size;
    // beats - 1, where a sub-word or single-word transfer is one beat of 4 bytes
    assign beat_init = (sel_size <= 4'd2) ? '0 : BW'((32'd1 << (sel_size - 4'd2)) - 32'd1);

    assign bus.tl_a_valid   = in_asend;
    assign bus.tl_a_opcode  = opcode_q;
    assign bus.tl_a_size    = size_q;
    assign bus.tl_a_address = addr_q;
    assign bus.tl_a_param   = 3'd0;
    assign bus.tl_a_mask    = in_asend ? 4'hF : 4'h0;
    assign bus.tl_a_data    = 32'd0;
    assign bus.tl_a_corrupt = 1'b0;

    assign owner_vld = in_dwait & bus.tl_d_valid & ~discard_q;
    assign owner_rdy = owner_q ? bus.req1_d_ready : bus.req0_d_ready;
    assign bus.tl_d_ready = in_dwait & (discard_q | owner_rdy);
    assign d_acc = bus.tl_d_valid & bus.tl_d_ready;

    assign bus.req0_d_valid   = owner_vld & ~owner_q;
    assign bus.req1_d_valid   = owner_vld & owner_q;
    // Payload is shared; only d_valid distinguishes the owner. Gated to zero outside D_WAIT.
    assign bus.req0_d_data    = in_dwait ? bus.tl_d_data : 32'd0;
    assign bus.req1_d_data    = in_dwait ? bus.tl_d_data : 32'd0;
    assign bus.req0_d_denied  = in_dwait & bus.tl_d_denied;
    assign bus.req1_d_denied  = in_dwait & bus.tl_d_denied;
    assign bus.req0_d_corrupt = in_dwait & bus.tl_d_corrupt;
    assign bus.req1_d_corrupt = in_dwait & bus.tl_d_corrupt;
    assign bus.req0_d_last    = in_dwait & (beat_q == '0);
    assign bus.req1_d_last    = in_dwait & (beat_q == '0);

    assign busy_o = ~in_idle;

    assign unused_d = ^{bus.tl_d_opcode, bus.tl_d_param, bus.tl_d_size};

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        starve_d  = starve_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        addr_d    = addr_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    state_d  = S_A_SEND;
                    owner_d  = grant1;
                    opcode_d = grant1 ? bus.req1_a_opcode  : bus.req0_a_opcode;
                    addr_d   = grant1 ? bus.req1_a_address : bus.req0_a_address;
                    size_d   = sel_size;
                    beat_d   = beat_init;
                    if (grant0 & bus.req1_a_valid)
                        starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
                    else
                        starve_d = '0;
                end
            end
            S_A_SEND: begin
                if (flush_i)
                    discard_d = 1'b1;
                if (bus.tl_a_ready)
                    state_d = S_D_WAIT;
            end
            S_D_WAIT: begin
                if (flush_i)
                    discard_d = 1'b1;
                if (d_acc) begin
                    if (beat_q == '0) begin
                        // Final beat ends the transaction even if a flush arrives with it.
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        beat_d = beat_q - BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            starve_q  <= '0;
            beat_q    <= '0;
            owner_q   <= 1'b0;
            opcode_q  <= 3'd0;
            size_q    <= 4'd0;
            addr_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            starve_q  <= starve_d;
            beat_q    <= beat_d;
            owner_q   <= owner_d;
            opcode_q  <= opcode_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_icache_tl_arbiter.sv
module tb_icache_tl_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_SIZE     = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    icache_tl_arbiter_if bus();

    icache_tl_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_SIZE(MAX_SIZE)) dut (
        .core_clock_i (clk),
        .core_reset_ni(rst_n),
        .flush_i      (flush),
        .busy_o       (busy),
        .bus          (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int starve_m = 0;   // reference: consecutive req0 wins while req1 waited

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.req0_a_valid)
            assert (bus.req0_a_size <= 4'(MAX_SIZE)) else begin
                errors++; $error("FAIL illegal_size0: observed %0d expected <=%0d", bus.req0_a_size, MAX_SIZE);
            end
        if (bus.req1_a_valid)
            assert (bus.req1_a_size <= 4'(MAX_SIZE)) else begin
                errors++; $error("FAIL illegal_size1: observed %0d expected <=%0d", bus.req1_a_size, MAX_SIZE);
            end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // One complete transaction. Starts and ends #1 after a rising edge in IDLE.
    // fm: 0 none, 1 flush in first A_SEND cycle, 2 flush in gap after beat fb,
    //     3 flush with last beat, 4 async reset mid-D_WAIT, 5 flush in IDLE with grant.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [3:0] s0, input logic [3:0] s1,
                          input logic [31:0] ad0, input logic [31:0] ad1,
                          input int a_delay, input int fm_in, input int fb,
                          input int stall_beat, input int stall_n,
                          output int obs_win);
        int          win, beats, fm;
        logic [3:0]  sz;
        logic [31:0] ad, dat;
        logic        den;
        bit          disc;

        win = (v1 && (!v0 || starve_m == STARVE_LIMIT)) ? 1 : 0;
        if (win == 0 && v1) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
        else                starve_m = 0;
        sz    = win ? s1 : s0;
        ad    = win ? ad1 : ad0;
        beats = (sz <= 2) ? 1 : (1 << (sz - 2));
        fm    = fm_in;
        if (fm == 2 && fb >= beats - 1) fm = 0;
        if (fm == 4 && beats < 2) fm = 0;

        bus.req0_a_valid = v0;  bus.req0_a_opcode = 3'd4; bus.req0_a_size = s0; bus.req0_a_address = ad0;
        bus.req1_a_valid = v1;  bus.req1_a_opcode = 3'd4; bus.req1_a_size = s1; bus.req1_a_address = ad1;
        flush = (fm == 5);
        #1;
        obs_win = int'(bus.req1_a_ready);
        chk("grant", {bus.req1_a_ready, bus.req0_a_ready}, win ? 2'b10 : 2'b01);
        chk("busy_idle", busy, 1'b0);
        @(posedge clk); #1;

        // Keep both requesters asking and scramble their addresses: nothing may be re-granted or re-latched.
        bus.req0_a_valid = 1'b1;
        bus.req1_a_valid = 1'b1;
        disc = (fm == 1);
        for (int c = 0; c <= a_delay; c++) begin
            flush = (fm == 1 && c == 0);
            bus.req0_a_address = $urandom;
            bus.req1_a_address = $urandom;
            bus.tl_a_ready = (c == a_delay);
            #1;
            chk("a_valid", bus.tl_a_valid, 1'b1);
            chk("a_fields", {bus.tl_a_opcode, bus.tl_a_size, bus.tl_a_address, bus.tl_a_mask,
                             bus.tl_a_param, bus.tl_a_corrupt, bus.tl_a_data},
                            {3'd4, sz, ad, 4'hF, 3'd0, 1'b0, 32'd0});
            chk("a_ready_busy", {bus.req1_a_ready, bus.req0_a_ready}, 2'b00);
            chk("busy_a", busy, 1'b1);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        bus.tl_a_ready = 1'b0;

        for (int b = 0; b < beats; b++) begin
            if (b == stall_beat && !disc) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.tl_d_valid = 1'b1;
                    bus.tl_d_data  = $urandom;
                    bus.req0_d_ready = (win == 1);
                    bus.req1_d_ready = (win == 0);
                    #1;
                    chk("stall_tl_d_ready", bus.tl_d_ready, 1'b0);
                    chk("stall_d_valid", {bus.req1_d_valid, bus.req0_d_valid}, win ? 2'b10 : 2'b01);
                    chk("stall_last", bus.req0_d_last, (b == beats - 1));
                    @(posedge clk); #1;
                end
            end
            dat = $urandom;
            den = 1'($urandom_range(0, 1));
            bus.tl_d_valid   = 1'b1;
            bus.tl_d_data    = dat;
            bus.tl_d_denied  = den;
            bus.tl_d_corrupt = 1'b0;
            bus.req0_d_ready = (win == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.req1_d_ready = (win == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            flush = (fm == 3 && b == beats - 1);
            if (fm == 4 && b == 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_tl", {bus.tl_a_valid, bus.tl_d_ready, bus.tl_a_mask, bus.tl_a_size,
                               bus.tl_a_address, bus.tl_a_opcode}, 64'd0);
                chk("rst_req", {bus.req0_d_valid, bus.req1_d_valid, bus.req0_d_last,
                                bus.req1_d_last, bus.req0_d_data}, 64'd0);
                bus.tl_d_valid   = 1'b0;
                bus.req0_a_valid = 1'b0;
                bus.req1_a_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                starve_m = 0;
                return;
            end
            #1;
            chk("d_valid", {bus.req1_d_valid, bus.req0_d_valid}, disc ? 2'b00 : (win ? 2'b10 : 2'b01));
            chk("tl_d_ready", bus.tl_d_ready, 1'b1);
            chk("a_ready_busy_d", {bus.req1_a_ready, bus.req0_a_ready}, 2'b00);
            if (!disc) begin
                chk("d_payload", {bus.req0_d_data, bus.req1_d_data}, {dat, dat});
                chk("d_flags", {bus.req0_d_denied, bus.req1_d_denied, bus.req0_d_last, bus.req1_d_last},
                               {den, den, (b == beats - 1), (b == beats - 1)});
            end
            @(posedge clk); #1;
            flush = 1'b0;
            bus.tl_d_valid = 1'b0;
            if (fm == 2 && b == fb) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                disc = 1'b1;
            end
        end
        chk("busy_end", busy, 1'b0);
        chk("a_valid_end", bus.tl_a_valid, 1'b0);
        bus.req0_a_valid = 1'b0;
        bus.req1_a_valid = 1'b0;
    endtask

    int w;
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit rv0, rv1;
    logic [3:0] rs0, rs1;
    int rfm;
    int fm_pick [5] = '{0, 1, 2, 3, 5};

    initial begin
        bus.req0_a_valid = 0; bus.req0_a_opcode = 3'd4; bus.req0_a_size = 0; bus.req0_a_address = 0;
        bus.req1_a_valid = 0; bus.req1_a_opcode = 3'd4; bus.req1_a_size = 0; bus.req1_a_address = 0;
        bus.req0_d_ready = 0; bus.req1_d_ready = 0;
        bus.tl_a_ready = 0;
        bus.tl_d_valid = 0; bus.tl_d_opcode = 3'd1; bus.tl_d_param = 2'd0; bus.tl_d_size = 4'd2;
        bus.tl_d_denied = 0; bus.tl_d_data = 0; bus.tl_d_corrupt = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_tl", {bus.tl_a_valid, bus.tl_d_ready, bus.tl_a_mask, bus.tl_a_size,
                         bus.tl_a_opcode, bus.tl_a_address}, 64'd0);
        chk("reset_req", {bus.req0_a_ready, bus.req1_a_ready, bus.req0_d_valid, bus.req1_d_valid,
                          bus.req0_d_last, bus.req1_d_last}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // req1 Get size 5 @0x1000, A held off for 3 cycles, 8 beats
        do_txn(0, 1, 4'd0, 4'd5, 32'h0, 32'h0000_1000, 3, 0, 0, -1, 0, w);

        // both requesting continuously
        for (int i = 0; i < 10; i++) begin
            do_txn(1, 1, 4'd2, 4'd3, 32'h100 + i, 32'h200 + i, 0, 0, 0, -1, 0, w);
            chk("contention_order", w, exp_order[i]);
        end

        // flush after beat 2 of a 4-beat burst
        do_txn(1, 0, 4'd4, 4'd0, 32'h0000_2000, 32'h0, 0, 2, 1, -1, 0, w);
        // flush in A_SEND while tl_a_ready is low
        do_txn(1, 0, 4'd3, 4'd0, 32'h0000_3000, 32'h0, 2, 1, 0, -1, 0, w);
        // owner back-pressure for 2 cycles mid-burst
        do_txn(1, 0, 4'd5, 4'd0, 32'h0000_4000, 32'h0, 1, 0, 0, 3, 2, w);
        // flush coinciding with the last beat, then a follow-up that must be delivered
        do_txn(0, 1, 4'd0, 4'd3, 32'h0, 32'h0000_5000, 0, 3, 0, -1, 0, w);
        do_txn(0, 1, 4'd0, 4'd1, 32'h0, 32'h0000_5100, 0, 0, 0, -1, 0, w);
        // async reset in D_WAIT, then a fresh grant
        do_txn(1, 0, 4'd4, 4'd0, 32'h0000_6000, 32'h0, 0, 4, 0, -1, 0, w);
        do_txn(1, 1, 4'd0, 4'd2, 32'h0000_7000, 32'h0000_7100, 0, 0, 0, -1, 0, w);
        // flush in IDLE alongside a grant has no effect
        do_txn(1, 0, 4'd3, 4'd0, 32'h0000_8000, 32'h0, 0, 5, 0, -1, 0, w);

        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rs0 = 4'($urandom_range(0, MAX_SIZE));
            rs1 = 4'($urandom_range(0, MAX_SIZE));
            rfm = fm_pick[$urandom_range(0, 4)];
            do_txn(rv0, rv1, rs0, rs1, $urandom, $urandom, $urandom_range(0, 3), rfm,
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 2), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
